// File: rtl/ahb_master_pkg.sv
// Shared types and constants for the AHB command master.
//   ADDR_W / DATA_W : bus address and data widths
//   HTRANS_*        : AHB transfer-type encodings used by the master
//   cmd_t           : one queued command {write, addr, wdata}
//   state_t         : address-phase pipeline state
package ahb_master_pkg;

  localparam int unsigned ADDR_W = 21;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

endpackage

// File: rtl/ahb_cmd_master_if.sv
// Command, response and AHB bus signals of the command master.
//   master : view of the ahb_cmd_master itself
//   slave  : view of the environment (command source, response sink, AHB slave)
interface ahb_cmd_master_if;
  import ahb_master_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              issue_en;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] rsp_addr;
  logic              busy;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [ADDR_W-1:0] HADDR;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, issue_en, HRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_addr, busy,
           HTRANS, HWRITE, HADDR, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, issue_en, HRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_addr, busy,
           HTRANS, HWRITE, HADDR, HWDATA
  );

endinterface

// File: rtl/cmd_fifo.sv
// Command FIFO, DEPTH entries (power of two), pointers wrap naturally.
//   clk, reset : clock, async active-high reset
//   push, pop  : enqueue din / dequeue head (caller guarantees !full / !empty)
//   dout       : head entry
//   empty, full, count : occupancy; full is a registered flag
module cmd_fifo
  import ahb_master_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  cmd_t                   din,
  output cmd_t                   dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;

  // Simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  // Pointers, count and registered full flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count_q == '0);
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: rtl/ahb_cmd_master.sv
// Queues read/write commands and issues them as single NONSEQ AHB transfers
// with pipelined address/data phases and a one-cycle turnaround on
// direction change. Read data is returned as a one-cycle rsp_valid strobe.
//   HCLK, reset : bus clock, async active-high reset
//   bus         : command in, response out, AHB master signals (master modport)
module ahb_cmd_master
  import ahb_master_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             HCLK,
  input  logic             reset,
  ahb_cmd_master_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  cmd_t              head;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic              push;
  logic              pop_c;
  logic              turn_need_c;

  state_t            state_q, state_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [DATA_W-1:0] awdata_q, awdata_d;
  logic [DATA_W-1:0] hwdata_q;
  logic              dvalid_q;
  logic              dwrite_q;
  logic [ADDR_W-1:0] daddr_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [ADDR_W-1:0] rsp_addr_q;

  assign push = bus.cmd_valid && !fifo_full;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (HCLK),
    .reset (reset),
    .push  (push),
    .pop   (pop_c),
    .din   ({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata}),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // A direction change right behind an address phase needs one IDLE gap.
  assign turn_need_c = (state_q == ST_ISSUE) && (hwrite_q != head.write);
  assign pop_c       = !fifo_empty && bus.issue_en && !turn_need_c;

  // Next address-phase state and bus values.
  always_comb begin
    state_d  = ST_IDLE;
    htrans_d = HTRANS_IDLE;
    hwrite_d = hwrite_q;
    haddr_d  = haddr_q;
    awdata_d = awdata_q;
    if (!fifo_empty && bus.issue_en) begin
      if (turn_need_c) begin
        state_d = ST_TURN;
      end else begin
        state_d  = ST_ISSUE;
        htrans_d = HTRANS_NONSEQ;
        hwrite_d = head.write;
        haddr_d  = head.addr;
        awdata_d = head.wdata;
      end
    end
  end

  // Address phase, data phase and response registers.
  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      haddr_q     <= '0;
      awdata_q    <= '0;
      hwdata_q    <= '0;
      dvalid_q    <= 1'b0;
      dwrite_q    <= 1'b0;
      daddr_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      haddr_q     <= haddr_d;
      awdata_q    <= awdata_d;
      dvalid_q    <= (state_q == ST_ISSUE);
      dwrite_q    <= hwrite_q;
      daddr_q     <= haddr_q;
      hwdata_q    <= ((state_q == ST_ISSUE) && hwrite_q) ? awdata_q : '0;
      rsp_valid_q <= dvalid_q && !dwrite_q;
      if (dvalid_q && !dwrite_q) begin
        rsp_rdata_q <= bus.HRDATA;
        rsp_addr_q  <= daddr_q;
      end
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.HTRANS    = htrans_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HADDR     = haddr_q;
  assign bus.HWDATA    = hwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.busy      = (fifo_count != '0) || (state_q == ST_ISSUE) ||
                         dvalid_q || rsp_valid_q;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master: drives commands, models a zero-wait
// AHB slave and checks bus/response timing against hand-derived values.
module tb_ahb_cmd_master;

  logic HCLK;
  logic reset;
  int   checks;
  int   errors;
  logic [7:0] slave_rdata;
  logic       rd_dphase;

  ahb_cmd_master_if bus ();

  ahb_cmd_master #(.DEPTH(4)) dut (
    .HCLK  (HCLK),
    .reset (reset),
    .bus   (bus.master)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Zero-wait slave: returns slave_rdata during a read's data phase only.
  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) rd_dphase <= 1'b0;
    else       rd_dphase <= (bus.HTRANS == 2'b10) && !bus.HWRITE;
  end
  assign bus.HRDATA = rd_dphase ? slave_rdata : 8'hEE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge HCLK);
  endtask

  task automatic offer(input logic w, input logic [20:0] a, input logic [7:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
  endtask

  task automatic no_cmd();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
  endtask

  task automatic check_rst(input string p);
    check({p, "_htrans"},    32'(bus.HTRANS),    32'h0);
    check({p, "_hwrite"},    32'(bus.HWRITE),    32'h0);
    check({p, "_haddr"},     32'(bus.HADDR),     32'h0);
    check({p, "_hwdata"},    32'(bus.HWDATA),    32'h0);
    check({p, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    check({p, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'h0);
    check({p, "_rsp_addr"},  32'(bus.rsp_addr),  32'h0);
    check({p, "_busy"},      32'(bus.busy),      32'h0);
    check({p, "_cmd_ready"}, 32'(bus.cmd_ready), 32'h1);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    slave_rdata = 8'h00;
    reset       = 1'b1;
    bus.issue_en = 1'b0;
    no_cmd();

    // Reset values
    cyc();
    cyc();
    check_rst("por");
    reset = 1'b0;

    // Single write 0x1A2B3 / 0x5C
    bus.issue_en = 1'b1;
    offer(1'b1, 21'h1A2B3, 8'h5C);
    cyc();                                  // E0-E1
    no_cmd();
    check("wr_e0_htrans", 32'(bus.HTRANS), 32'h0);
    check("wr_e0_busy",   32'(bus.busy),   32'h1);
    cyc();                                  // E1-E2
    check("wr_e1_htrans", 32'(bus.HTRANS), 32'h2);
    check("wr_e1_haddr",  32'(bus.HADDR),  32'h1A2B3);
    check("wr_e1_hwrite", 32'(bus.HWRITE), 32'h1);
    cyc();                                  // E2-E3
    check("wr_e2_htrans", 32'(bus.HTRANS), 32'h0);
    check("wr_e2_hwdata", 32'(bus.HWDATA), 32'h5C);
    check("wr_e2_haddr_hold", 32'(bus.HADDR), 32'h1A2B3);
    cyc();                                  // E3-E4
    check("wr_e3_hwdata", 32'(bus.HWDATA), 32'h0);
    check("wr_e3_rsp",    32'(bus.rsp_valid), 32'h0);
    check("wr_e3_busy",   32'(bus.busy),   32'h0);

    // Single read 0x1A2B3, slave returns 0x5C
    slave_rdata = 8'h5C;
    offer(1'b0, 21'h1A2B3, 8'h00);
    cyc();                                  // E0-E1
    no_cmd();
    cyc();                                  // E1-E2
    check("rd_e1_htrans", 32'(bus.HTRANS), 32'h2);
    check("rd_e1_hwrite", 32'(bus.HWRITE), 32'h0);
    check("rd_e1_rsp",    32'(bus.rsp_valid), 32'h0);
    cyc();                                  // E2-E3
    check("rd_e2_hwdata", 32'(bus.HWDATA), 32'h0);
    check("rd_e2_rsp",    32'(bus.rsp_valid), 32'h0);
    cyc();                                  // E3-E4
    check("rd_e3_rsp",    32'(bus.rsp_valid), 32'h1);
    check("rd_e3_rdata",  32'(bus.rsp_rdata), 32'h5C);
    check("rd_e3_addr",   32'(bus.rsp_addr),  32'h1A2B3);
    cyc();                                  // E4-E5
    check("rd_e4_rsp",    32'(bus.rsp_valid), 32'h0);
    check("rd_e4_busy",   32'(bus.busy),      32'h0);

    // Fill with issue disabled: 5 offered, 4 accepted
    bus.issue_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(1'b1, 21'h00100 + 21'(i), 8'h10 + 8'(i));
      check($sformatf("fill_ready_%0d", i), 32'(bus.cmd_ready), (i < 4) ? 32'h1 : 32'h0);
      cyc();
    end
    no_cmd();
    check("fill_htrans", 32'(bus.HTRANS), 32'h0);
    check("fill_busy",   32'(bus.busy),   32'h1);
    bus.issue_en = 1'b1;
    cyc();                                  // first pop just happened
    check("drain_ready", 32'(bus.cmd_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_htrans_%0d", i), 32'(bus.HTRANS), 32'h2);
      check($sformatf("drain_haddr_%0d", i),  32'(bus.HADDR),  32'h00100 + 32'(i));
      if (i > 0)
        check($sformatf("drain_hwdata_%0d", i), 32'(bus.HWDATA), 32'h10 + 32'(i - 1));
      cyc();
    end
    check("drain_end_htrans", 32'(bus.HTRANS), 32'h0);
    check("drain_end_hwdata", 32'(bus.HWDATA), 32'h13);
    cyc();
    cyc();
    check("drain_idle_busy", 32'(bus.busy), 32'h0);

    // Write 0x00010 then read 0x00020 back-to-back: turnaround
    slave_rdata = 8'h77;
    offer(1'b1, 21'h00010, 8'h33);
    cyc();                                  // E0-E1
    offer(1'b0, 21'h00020, 8'h00);
    check("ta_e0_htrans", 32'(bus.HTRANS), 32'h0);
    cyc();                                  // E1-E2
    no_cmd();
    check("ta_e1_htrans", 32'(bus.HTRANS), 32'h2);
    check("ta_e1_haddr",  32'(bus.HADDR),  32'h00010);
    cyc();                                  // E2-E3
    check("ta_e2_htrans", 32'(bus.HTRANS), 32'h0);
    check("ta_e2_hwdata", 32'(bus.HWDATA), 32'h33);
    cyc();                                  // E3-E4
    check("ta_e3_htrans", 32'(bus.HTRANS), 32'h2);
    check("ta_e3_haddr",  32'(bus.HADDR),  32'h00020);
    check("ta_e3_hwrite", 32'(bus.HWRITE), 32'h0);
    cyc();                                  // E4-E5
    check("ta_e4_htrans", 32'(bus.HTRANS), 32'h0);
    check("ta_e4_hwdata", 32'(bus.HWDATA), 32'h0);
    cyc();                                  // E5-E6
    check("ta_e5_rsp",   32'(bus.rsp_valid), 32'h1);
    check("ta_e5_rdata", 32'(bus.rsp_rdata), 32'h77);
    check("ta_e5_addr",  32'(bus.rsp_addr),  32'h00020);
    cyc();

    // Two pipelined reads; reset during the first read's data phase
    slave_rdata = 8'h5C;
    offer(1'b0, 21'h0ABCD, 8'h00);
    cyc();                                  // E0-E1
    offer(1'b0, 21'h0ABCE, 8'h00);
    cyc();                                  // E1-E2
    no_cmd();
    check("pipe_e1_htrans", 32'(bus.HTRANS), 32'h2);
    check("pipe_e1_haddr",  32'(bus.HADDR),  32'h0ABCD);
    cyc();                                  // E2-E3
    check("pipe_e2_htrans", 32'(bus.HTRANS), 32'h2);
    check("pipe_e2_haddr",  32'(bus.HADDR),  32'h0ABCE);
    reset = 1'b1;
    #1;
    check_rst("rst_mid");
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("post_rst_rsp_%0d", i),    32'(bus.rsp_valid), 32'h0);
      check($sformatf("post_rst_busy_%0d", i),   32'(bus.busy),      32'h0);
      check($sformatf("post_rst_htrans_%0d", i), 32'(bus.HTRANS),    32'h0);
      cyc();
    end

    // Read after reset works normally
    slave_rdata = 8'hA7;
    offer(1'b0, 21'h00055, 8'h00);
    cyc();                                  // E0-E1
    no_cmd();
    cyc();                                  // E1-E2
    check("rec_e1_htrans", 32'(bus.HTRANS), 32'h2);
    check("rec_e1_haddr",  32'(bus.HADDR),  32'h00055);
    cyc();                                  // E2-E3
    check("rec_e2_rsp",    32'(bus.rsp_valid), 32'h0);
    cyc();                                  // E3-E4
    check("rec_e3_rsp",    32'(bus.rsp_valid), 32'h1);
    check("rec_e3_rdata",  32'(bus.rsp_rdata), 32'hA7);
    check("rec_e3_addr",   32'(bus.rsp_addr),  32'h00055);
    cyc();
    check("rec_e4_rsp",    32'(bus.rsp_valid), 32'h0);
    check("rec_e4_busy",   32'(bus.busy),      32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 SHALL have parameter DEPTH, default 4: command FIFO entries; power of two, at least 2.
REQ-002 SHALL have ports (name, direction, width, meaning):
- HCLK  in  1  bus clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  21  byte address.
- cmd_wdata  in  8  write data.
- issue_en  in  1  permits new address phases.
- rsp_valid  out  1  one-cycle read-data strobe.
- rsp_rdata  out  8  returned read data.
- rsp_addr  out  21  address of the returned read.
- busy  out  1  FIFO non-empty or a transfer is in flight.
- HTRANS  out  2  AHB transfer type.
- HWRITE  out  1  AHB direction.
- HADDR  out  21  AHB address.
- HWDATA  out  8  AHB write data.
- HRDATA  in  8  AHB read data.

Function
REQ-003 SHALL push {cmd_write, cmd_addr, cmd_wdata} into the FIFO on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-004 SHALL drive cmd_ready = !full from registered state, with no combinational path from cmd_valid.
REQ-005 SHALL handle a simultaneous push and pop with the count unchanged; a push while full SHALL NOT occur, because cmd_ready=0.
REQ-006 SHALL pop the head entry at a rising edge when the FIFO is non-empty, issue_en=1, and no turnaround is pending.
- The popped entry's address phase is the following cycle.
- HTRANS=2'b10 (NONSEQ), HWRITE=cmd_write, HADDR=cmd_addr.
REQ-007 SHALL drive HTRANS=2'b00 (IDLE) in cycles with no address phase, with HADDR and HWRITE holding their last values.
REQ-008 SHALL make the data phase the cycle after the address phase; all bus outputs SHALL be registered.
- Write: HWDATA = the entry's wdata.
- Otherwise: HWDATA = 0.
REQ-009 SHALL sample HRDATA for a read at the rising edge ending its data phase, then drive rsp_valid=1 for exactly one cycle with rsp_rdata and rsp_addr.
REQ-010 SHALL have latency: handshake at edge E0 with an empty FIFO and issue_en=1 gives:
- address phase E1-E2;
- data phase E2-E3;
- rsp_valid E3-E4.
REQ-011 SHALL issue back-to-back same-direction transfers in consecutive cycles (pipelined address/data overlap).
REQ-012 SHALL insert exactly one IDLE address-phase cycle when the next transfer's direction differs from the previous issued transfer (write->read or read->write turnaround).
REQ-013 SHALL let a transfer whose address phase already started complete normally when issue_en deasserts; no further pops occur.
REQ-014 SHALL use the pipeline states IDLE, ISSUE (address phase active), TURN (turnaround gap); the data phase is tracked by a separate valid/direction register.
REQ-015 SHALL drive busy = (count!=0) | address-phase active | data-phase active | rsp pending.
REQ-016 SHALL wrap FIFO pointers modulo DEPTH, with count width clog2(DEPTH)+1.

Reset
REQ-017 SHALL, while reset=1, immediately set:
- HTRANS=0, HWRITE=0, HADDR=0, HWDATA=0;
- rsp_valid=0, rsp_rdata=0, rsp_addr=0;
- busy=0, cmd_ready=1;
- FIFO empty, state IDLE.
REQ-018 SHALL discard on a reset mid-operation all queued and in-flight commands, with no rsp_valid produced for them.

Structure
REQ-019 SHALL place in shared package ahb_master_pkg:
- ADDR_W=21 and DATA_W=8;
- HTRANS_IDLE=2'b00 and HTRANS_NONSEQ=2'b10;
- the command struct typedef;
- the state enum.
REQ-020 SHALL implement the FIFO as sub-module cmd_fifo (parameter DEPTH), instantiated once.

Verification
REQ-021 SHALL cover: reset asserted mid-run -> all outputs at REQ-017 values within the same cycle; cmd_ready=1.
REQ-022 SHALL cover: write 0x1A2B3/0x5C, FIFO empty -> HTRANS=10, HADDR=0x1A2B3, HWRITE=1 in cycle E1; HWDATA=0x5C in cycle E2; HTRANS=00 in E2.
REQ-023 SHALL cover: read 0x1A2B3 with the model returning HRDATA=0x5C in the data phase -> rsp_valid=1 at E3 only, rsp_rdata=0x5C, rsp_addr=0x1A2B3.
REQ-024 SHALL cover: issue_en=0, five writes offered -> four accepted, cmd_ready=0 after the 4th; then issue_en=1 -> four consecutive NONSEQ cycles, and cmd_ready=1 the cycle after the first pop.
REQ-025 SHALL cover: write 0x00010 then read 0x00020 back-to-back -> HTRANS sequence 10,00,10; the read's HWDATA=0.
REQ-026 SHALL cover: reset pulsed during a read's data phase -> no rsp_valid, busy=0, and a later read works normally.
